// File: rtl/ls153_scan_if.sv
// ls153_scan_if: bus bundle for the ls153_scan selector array and scan sequencer.
`default_nettype none

interface ls153_scan_if #(
  parameter int CH      = 2,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
);
  logic [CH-1:0]              g;
  logic [CH*(1<<SEL_W)-1:0]   c;
  logic [SEL_W-1:0]           sel;
  logic                       mode;
  logic [DWELL_W-1:0]         dwell;
  logic                       hold;
  logic [CH-1:0]              y;
  logic [SEL_W-1:0]           scan;
  logic                       step;
  logic                       wrap;

  modport master (
    output g, c, sel, mode, dwell, hold,
    input  y, scan, step, wrap
  );

  modport slave (
    input  g, c, sel, mode, dwell, hold,
    output y, scan, step, wrap
  );
endinterface

`default_nettype wire

// File: rtl/ls153_scan.sv
// ls153_scan: CH registered 2^SEL_W:1 selectors with active-low strobes and a dwell-timed scan sequencer.
// Optional macro LS153_SCAN_WRAP_EN builds the registered wrap pulse; otherwise wrap is tied low.
`default_nettype none

module ls153_scan #(
  parameter int CH      = 2,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ls153_scan_if.slave  bus
);
  localparam int N = 1 << SEL_W;

  logic               mode_q;
  logic               adv_q, adv_d;
  logic [SEL_W-1:0]   sc_q, sc_d, sc_eff;
  logic [DWELL_W-1:0] d_q, d_d, d_eff;
  logic [SEL_W-1:0]   scan_q, sel_w;
  logic [CH-1:0]      y_q, y_d;
  logic               step_q, step_d;
  logic               entering;
  logic [N-1:0]       ch_w;

  always_comb begin
    entering = bus.mode & ~mode_q;
    // A fresh entry into scan mode behaves as if the sequencer sat at input 0 with no elapsed dwell.
    sc_eff   = entering ? '0 : sc_q;
    d_eff    = entering ? '0 : d_q;
    sel_w    = bus.mode ? sc_eff : bus.sel;

    y_d  = '0;
    ch_w = '0;
    for (int ch = 0; ch < CH; ch++) begin
      ch_w     = bus.c[ch*N +: N];
      y_d[ch]  = ~bus.g[ch] & ch_w[sel_w];
    end

    sc_d  = sc_eff;
    d_d   = d_eff;
    adv_d = 1'b0;
    if (bus.mode && !bus.hold) begin
      // >= rather than == so a dwell lowered under the running count still advances.
      if (d_eff >= bus.dwell) begin
        d_d   = '0;
        sc_d  = sc_eff + 1'b1;
        adv_d = 1'b1;
      end else begin
        d_d = d_eff + 1'b1;
      end
    end

    step_d = bus.mode & ~entering & adv_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= 1'b0;
      adv_q  <= 1'b0;
      sc_q   <= '0;
      d_q    <= '0;
      y_q    <= '0;
      scan_q <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      adv_q  <= adv_d;
      sc_q   <= sc_d;
      d_q    <= d_d;
      y_q    <= y_d;
      scan_q <= sel_w;
      step_q <= step_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.scan = scan_q;
  assign bus.step = step_q;

`ifdef LS153_SCAN_WRAP_EN
  logic wrap_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step_d & (sel_w == '0);
    end
  end

  assign bus.wrap = wrap_q;
`else
  assign bus.wrap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ls153_scan.sv
// tb_ls153_scan: directed test-plan sequences with literal expectations, then randomized traffic against a behavioural model.
`default_nettype none

module tb_ls153_scan;
  localparam int CH      = 2;
  localparam int SEL_W   = 2;
  localparam int DWELL_W = 8;
  localparam int N       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ls153_scan_if #(.CH(CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  ls153_scan #(.CH(CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: current scan position, cycles already spent on it, and a pending "new value" flag.
  bit            m_valid = 1'b0;
  bit            m_prev_mode;
  int            m_cur;
  int            m_used;
  bit            m_pend;
  logic [CH-1:0] e_y;
  int            e_scan;
  bit            e_step;
  bit            e_wrap;

  always @(posedge clk) begin
    int  s;
    bit  entering;
    if (rst) begin
      e_y = '0; e_scan = 0; e_step = 0; e_wrap = 0;
      m_prev_mode = 0; m_cur = 0; m_used = 0; m_pend = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      entering = bus.mode && !m_prev_mode;
      if (entering) begin
        m_cur  = 0;
        m_used = 0;
      end
      s = bus.mode ? m_cur : int'(bus.sel);
      for (int ch = 0; ch < CH; ch++)
        e_y[ch] = bus.g[ch] ? 1'b0 : bus.c[ch*N + s];
      e_scan = s;
      e_step = bus.mode && !entering && m_pend;
`ifdef LS153_SCAN_WRAP_EN
      e_wrap = e_step && (s == 0);
`else
      e_wrap = 1'b0;
`endif
      m_pend = 1'b0;
      if (bus.mode && !bus.hold) begin
        if (m_used >= int'(bus.dwell)) begin
          m_used = 0;
          m_cur  = (m_cur + 1) % N;
          m_pend = 1'b1;
        end else begin
          m_used = m_used + 1;
        end
      end
      m_prev_mode = bus.mode;
    end
    #1;
    if (m_valid) begin
      check("model_y",    bus.y,    e_y);
      check("model_scan", bus.scan, e_scan);
      check("model_step", bus.step, e_step);
      check("model_wrap", bus.wrap, e_wrap);
    end
  end

  logic [1:0] ext_y [4] = '{2'b10, 2'b10, 2'b01, 2'b10};

  initial begin
    int ones;
    bit found;
    bus.g = '0; bus.c = 8'hFF; bus.sel = '0; bus.mode = 1'b1; bus.dwell = '0; bus.hold = 1'b0;
    rst = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check("rst_y", bus.y, 0);
      check("rst_scan", bus.scan, 0);
      check("rst_step", bus.step, 0);
      check("rst_wrap", bus.wrap, 0);
    end

    // External select
    rst = 1'b0; bus.mode = 1'b0; bus.c = 8'hB4;
    for (int i = 0; i < 4; i++) begin
      bus.sel = 2'(i);
      @(negedge clk);
      check("ext_y", bus.y, ext_y[i]);
      check("ext_scan", bus.scan, i);
      check("ext_step", bus.step, 0);
    end

    // Strobes
    bus.sel = 2'd2; bus.g = 2'b11;
    @(negedge clk); check("strobe_11", bus.y, 2'b00);
    bus.g = 2'b10;
    @(negedge clk); check("strobe_10", bus.y, 2'b01);
    bus.g = 2'b01;
    @(negedge clk); check("strobe_01", bus.y, 2'b00);

    // Scan with dwell 2
    bus.g = 2'b00; bus.c = 8'h5A; bus.dwell = 8'd2; bus.mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("scan_val", bus.scan, (i / 3) % 4);
      check("scan_y0", bus.y[0], ((i / 3) % 4) % 2);
      check("scan_step", bus.step, (i % 3 == 0 && i > 0) ? 1 : 0);
`ifdef LS153_SCAN_WRAP_EN
      check("scan_wrap", bus.wrap, (i == 12) ? 1 : 0);
`else
      check("scan_wrap", bus.wrap, 0);
`endif
    end

    // Hold for 5 cycles starting on the second cycle of scan value 1
    bus.mode = 1'b0;
    @(negedge clk);
    bus.mode = 1'b1; bus.dwell = 8'd3;
    ones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.scan === 2'd1) ones++;
      if (i == 5)  bus.hold = 1'b1;
      if (i == 10) bus.hold = 1'b0;
      if (bus.hold) bus.c[1] = ~bus.c[1];
    end
    check("hold_len", ones, 9);

    // Reset in the middle of scan value 2
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.scan === 2'd2) found = 1'b1;
    end
    check("find_scan2", found, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_y", bus.y, 0);
    check("midrst_scan", bus.scan, 0);
    check("midrst_step", bus.step, 0);
    check("midrst_wrap", bus.wrap, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_scan", bus.scan, (i < 4) ? 0 : 1);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 31) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 15) == 0) bus.dwell = 8'($urandom_range(0, 5));
      bus.hold = ($urandom_range(0, 7) == 0);
      bus.g    = 2'($urandom);
      bus.c    = 8'($urandom);
      bus.sel  = 2'($urandom);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ls153_scan.md
# ls153_scan

Parametrised successor to the dual 4-line to 1-line selector model, for the logic-model library. It provides CH independent 2^SEL_W-to-1 selectors with registered outputs, per-channel active-low strobe, and a built-in scan sequencer. The sequencer steps the shared select through all inputs with a programmable dwell. Typical use: time-multiplexed sampling of data lines such as display digit scan or input-matrix polling, where external TTL counters previously drove the select pins.

## Interface
Parameters:
- CH, 2, number of selector channels (≥1)
- SEL_W, 2, select width; inputs per channel N = 2^SEL_W
- DWELL_W, 8, width of the dwell (cycles-per-step) control

Ports:
- _CLK  in  1  single clock; all state on rising edge
- _RST  in  1  reset, synchronous, active-high
- _G  in  CH  per-channel strobe, active-low; 1 forces that channel's output low
- _C  in  CH*N  packed data; channel c input i at bit c*N+i
- _SEL  in  SEL_W  external select (used when _MODE=0)
- _MODE  in  1  0 = external select, 1 = internal scan
- _DWELL  in  DWELL_W  scan dwell; each select value held _DWELL+1 cycles
- _HOLD  in  1  freezes the scan sequencer (outputs keep sampling)
- _Y  out  CH  registered selector outputs
- _SCAN  out  SEL_W  select value that produced the current _Y
- _STEP  out  1  one-cycle pulse on first cycle _SCAN shows a new scan value
- _WRAP  out  1  one-cycle pulse coincident with _STEP when _SCAN returns to 0 (see Configuration)

## Operation
- Internal state: scan counter sc (SEL_W), dwell counter d (DWELL_W), registered previous mode.
- Effective select s: _SEL when _MODE=0, otherwise sc (pre-edge value).
- Every edge, not in reset: _Y[c] <= _G[c] ? 0 : _C[c*N+s]; _SCAN <= s.
- Sequencer, _MODE=1, _HOLD=0: if d >= _DWELL, then d <= 0 and sc <= sc+1 mod N (wraps N-1 -> 0); else d <= d+1.
- _HOLD=1: d and sc frozen. _Y/_SCAN keep updating from the frozen sc.
- _MODE=0: sequencer idle, sc and d retain their values.
- Mode 0->1 transition (registered mode was 0, _MODE now 1): sc <= 0, d <= 0 at that edge. Scan starts at input 0 with full dwell. The select for that edge's _Y is 0.
- _DWELL reduced below the current d: the >= compare advances on the next edge; there is no overflow lockup.
- _STEP registered: high for the one cycle in which _SCAN first holds a post-advance value in scan mode. Never asserted in external mode.
- Reset (any time, including mid-dwell): _Y=0, _SCAN=0, _STEP=0, _WRAP=0, sc=0, d=0, registered mode=0.

## Timing
- Select/data/strobe to _Y: 1 cycle latency. _Y and _SCAN are always a coherent pair.
- After reset release with _MODE=1 and _DWELL=D: sc advances on edges D+1, 2(D+1), …. _SCAN shows each value for exactly D+1 cycles. _SCAN lags sc by one cycle.
- D=0: _SCAN increments every cycle and _STEP is held high continuously.
- Full scan period: N*(D+1) cycles, plus any _HOLD cycles.
- A _HOLD asserted for H cycles extends the current step by exactly H cycles. The remaining dwell is preserved.
- Simultaneous _RST and any other input: reset wins.

## Configuration
- Macro LS153_SCAN_WRAP_EN.
- Defined: _WRAP is a registered pulse, high exactly when _STEP is high and _SCAN=0.
- Undefined: _WRAP is tied 0 (port retained) and no wrap-detect logic is built. All other behaviour is identical.

## Test plan
Defaults: CH=2, SEL_W=2, DWELL_W=8; LS153_SCAN_WRAP_EN defined unless stated.
- Reset: _RST=1 for 2 cycles with _MODE=1, _C=8'hFF, _G=00 -> _Y=00, _SCAN=0, _STEP=0, _WRAP=0 throughout and on the first post-reset cycle before sampling.
- External mode: _MODE=0, _G=00, ch0=4'b0100, ch1=4'b1011, _SEL=0,1,2,3 on consecutive cycles -> one cycle later _Y={ch1,ch0}=10,10,01,10 with _SCAN=0,1,2,3; _STEP stays 0.
- Strobes: _SEL=2 with the same data, then _G=11 -> _Y=00 next cycle; then _G=10 -> _Y=01; then _G=01 -> _Y=00.
- Scan: _MODE 0->1, _DWELL=2, ch0=4'b1010, _G=00 -> _SCAN=0,0,0,1,1,1,2,2,2,3,3,3,0…; _Y[0]=0,1,0,1 per step; _STEP on each first new value; _WRAP only at the 3->0 step. Rebuild without the macro -> _WRAP constantly 0.
- Hold: in scan mode with _DWELL=3, assert _HOLD for 5 cycles on the second cycle of _SCAN=1 -> _SCAN=1 persists for 4+5=9 cycles total; _Y tracks ch0 bit 1 toggling during the hold.
- Reset mid-operation: _RST pulse while _SCAN=2, d=1 -> next cycle all outputs 0; after release, _SCAN=0 held _DWELL+1 cycles, then sequencing resumes from 1.
